// File: rtl/awgn_pkg.sv
// Shared constants and types for the AWGN sample shaper.
//   W         : default sample width (signed two's complement)
//   GAIN_FRAC : default fractional bits of the Q4.12 sigma gain
//   SAT_MAX / SAT_MIN : clamp limits for a W-bit signed sample
//   pair_t    : one Gaussian pair as captured from myAWGN, x0 in the upper half
//   phase_t   : read-side selector, which sample of the head pair goes out next
package awgn_pkg;

  localparam int unsigned W         = 16;
  localparam int unsigned GAIN_FRAC = 12;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic signed [W-1:0] x0;
    logic signed [W-1:0] x1;
  } pair_t;

  typedef enum logic {
    PH_X0 = 1'b0,
    PH_X1 = 1'b1
  } phase_t;

endpackage

// File: rtl/awgn_pair_fifo.sv
// Synchronous FIFO of WIDTH-bit entries (one Gaussian pair per entry).
//   clk, resetn : rising-edge clock, synchronous active-low reset
//   push, din   : write strobe and data; ignored when full
//   pop, dout   : read strobe and head entry (dout is the head, valid when !empty)
//   full, empty : occupancy flags derived from the pre-edge count
//   count       : number of stored entries, $clog2(DEPTH)+1 bits
module awgn_pair_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/awgn_sample_shaper.sv
// Buffers myAWGN (x0, x1) pairs and serialises them as x0, x1, ... scaled by a
// Q4.12 sigma gain with round-half-up and saturation, on a valid/ready output.
//   clk, resetn        : rising-edge clock, synchronous active-low reset
//   x0, x1, ivalid     : incoming pair, no backpressure
//   gain               : unsigned Q4.12 multiplier, sampled on each output load
//   noise, noise_valid : scaled sample and its valid flag
//   noise_ready        : consumer accepts the current sample
//   drop_cnt           : pairs lost to a full FIFO, saturating
//   overflow           : sticky, set on the first drop
module awgn_sample_shaper #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned W         = awgn_pkg::W,
  parameter int unsigned GAIN_FRAC = awgn_pkg::GAIN_FRAC
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic                ivalid,
  input  logic [15:0]         gain,
  output logic signed [W-1:0] noise,
  output logic                noise_valid,
  input  logic                noise_ready,
  output logic [15:0]         drop_cnt,
  output logic                overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = W + 17;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic signed [PW-1:0] HALF   = {{(PW-1){1'b0}}, 1'b1} <<< (GAIN_FRAC - 1);
  localparam logic signed [PW-1:0] HI     = {{18{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] LO     = {{18{1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  SAT_HI = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  SAT_LO = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic signed [W-1:0] x0;
    logic signed [W-1:0] x1;
  } pair_w_t;

  pair_w_t          wr_pair;
  pair_w_t          head;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic             load;

  awgn_pkg::phase_t phase_q;
  awgn_pkg::phase_t phase_d;

  logic signed [W-1:0]  sample;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rounded;
  logic signed [W-1:0]  sat;

  assign wr_pair = {x0, x1};
  assign push    = ivalid && (fifo_count < DEPTH_C);
  assign drop    = ivalid && fifo_full;
  assign load    = !fifo_empty && (!noise_valid || noise_ready);

  awgn_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (wr_pair),
    .pop    (pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) phase_q <= awgn_pkg::PH_X0;
    else         phase_q <= phase_d;
  end

  // The head pair is released only once its x1 has been loaded.
  always_comb begin
    phase_d = phase_q;
    pop     = 1'b0;
    sample  = (phase_q == awgn_pkg::PH_X1) ? head.x1 : head.x0;
    if (load) begin
      phase_d = (phase_q == awgn_pkg::PH_X1) ? awgn_pkg::PH_X0 : awgn_pkg::PH_X1;
      pop     = (phase_q == awgn_pkg::PH_X1);
    end
  end

  // Gain is zero-extended so the product treats it as unsigned.
  assign prod    = sample * $signed({1'b0, gain});
  assign rounded = (prod + HALF) >>> GAIN_FRAC;

  always_comb begin
    sat = rounded[W-1:0];
    if (rounded > HI)      sat = SAT_HI;
    else if (rounded < LO) sat = SAT_LO;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      noise       <= '0;
      noise_valid <= 1'b0;
    end else if (load) begin
      noise       <= sat;
      noise_valid <= 1'b1;
    end else if (noise_ready) begin
      noise_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_awgn_sample_shaper.sv
// Directed self-checking bench for awgn_sample_shaper (DEPTH = 8, W = 16).
module tb_awgn_sample_shaper;

  logic               clk;
  logic               resetn;
  logic signed [15:0] x0;
  logic signed [15:0] x1;
  logic               ivalid;
  logic [15:0]        gain;
  logic signed [15:0] noise;
  logic               noise_valid;
  logic               noise_ready;
  logic [15:0]        drop_cnt;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  awgn_sample_shaper #(
    .DEPTH     (8),
    .W         (16),
    .GAIN_FRAC (12)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .x0          (x0),
    .x1          (x1),
    .ivalid      (ivalid),
    .gain        (gain),
    .noise       (noise),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready),
    .drop_cnt    (drop_cnt),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    x0     = a;
    x1     = b;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    ivalid      = 1'b0;
    x0          = '0;
    x1          = '0;
    gain        = 16'h1000;
    noise_ready = 1'b0;
    tick();
    tick();
    chk("rst_noise", noise, 16'h0000);
    chk("rst_valid", {15'd0, noise_valid}, 16'h0000);
    chk("rst_drop", drop_cnt, 16'h0000);
    chk("rst_ovf", {15'd0, overflow}, 16'h0000);
    resetn      = 1'b1;
    noise_ready = 1'b1;
    tick();

    // Unity gain, basic latency
    send_pair(16'h0100, 16'hFF00);
    chk("unity_k_valid", {15'd0, noise_valid}, 16'h0000);
    tick();
    chk("unity_k1_valid", {15'd0, noise_valid}, 16'h0001);
    chk("unity_k1_noise", noise, 16'h0100);
    tick();
    chk("unity_k2_valid", {15'd0, noise_valid}, 16'h0001);
    chk("unity_k2_noise", noise, 16'hFF00);
    tick();
    chk("unity_k3_valid", {15'd0, noise_valid}, 16'h0000);

    // Saturation: 0x4000 * 4.0 and -0x8000 * 4.0
    gain = 16'h4000;
    send_pair(16'h4000, 16'h8000);
    tick();
    chk("sat_hi", noise, 16'h7FFF);
    tick();
    chk("sat_lo", noise, 16'h8000);
    tick();
    chk("sat_idle", {15'd0, noise_valid}, 16'h0000);

    // Rounding: 3 * 0.5 = 1.5 -> 2, -3 * 0.5 = -1.5 -> -1
    gain = 16'h0800;
    send_pair(16'h0003, 16'hFFFD);
    tick();
    chk("rnd_pos", noise, 16'h0002);
    tick();
    chk("rnd_neg", noise, 16'hFFFF);
    tick();
    chk("rnd_idle", {15'd0, noise_valid}, 16'h0000);

    // Overflow: 10 back-to-back pairs with the consumer stalled
    gain        = 16'h1000;
    noise_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_pair(16'(16'h1000 + 2*i), 16'(16'h1001 + 2*i));
    end
    chk("ovf_drop", drop_cnt, 16'd2);
    chk("ovf_flag", {15'd0, overflow}, 16'h0001);
    chk("ovf_valid", {15'd0, noise_valid}, 16'h0001);
    chk("ovf_head", noise, 16'h1000);

    // Stall: held sample must survive a gain change
    gain = 16'h2000;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_noise", noise, 16'h1000);
      chk("stall_valid", {15'd0, noise_valid}, 16'h0001);
    end
    gain = 16'h1000;

    // Drain; a pair offered on the first pop edge finds the FIFO still full
    noise_ready = 1'b1;
    x0          = 16'hAAAA;
    x1          = 16'hBBBB;
    ivalid      = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("drain_noise", noise, 16'(16'h1000 + j));
      chk("drain_valid", {15'd0, noise_valid}, 16'h0001);
      tick();
      ivalid = 1'b0;
    end
    chk("drain_end_valid", {15'd0, noise_valid}, 16'h0000);
    chk("drain_drop", drop_cnt, 16'd3);
    chk("drain_ovf", {15'd0, overflow}, 16'h0001);

    // Reset mid-stream with 3 pairs buffered
    noise_ready = 1'b0;
    send_pair(16'h0111, 16'h0222);
    send_pair(16'h0333, 16'h0444);
    send_pair(16'h0555, 16'h0666);
    chk("pre_rst_valid", {15'd0, noise_valid}, 16'h0001);
    chk("pre_rst_noise", noise, 16'h0111);
    resetn = 1'b0;
    tick();
    chk("mid_rst_noise", noise, 16'h0000);
    chk("mid_rst_valid", {15'd0, noise_valid}, 16'h0000);
    chk("mid_rst_drop", drop_cnt, 16'h0000);
    chk("mid_rst_ovf", {15'd0, overflow}, 16'h0000);
    resetn      = 1'b1;
    noise_ready = 1'b1;
    send_pair(16'h0123, 16'h0456);
    chk("post_rst_k_valid", {15'd0, noise_valid}, 16'h0000);
    tick();
    chk("post_rst_k1_valid", {15'd0, noise_valid}, 16'h0001);
    chk("post_rst_x0", noise, 16'h0123);
    tick();
    chk("post_rst_x1", noise, 16'h0456);
    tick();
    chk("post_rst_idle", {15'd0, noise_valid}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/awgn_sample_shaper.md
# awgn_sample_shaper

Downstream consumer of the `myAWGN` pair outputs. It captures each (x0, x1) Gaussian sample pair on `ivalid` into a small pair FIFO and serialises the pairs into a single stream of samples, x0 first, then x1. Each sample is scaled by a programmable sigma gain, rounded, and saturated before being presented on a valid/ready output toward the channel-model adder. Pairs that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `DEPTH`, default 8: pair FIFO depth in pairs; power of two, ≥2.
- `W`, default 16: sample width; signed two's complement.
- `GAIN_FRAC`, default 12: fractional bits of `gain` (Q4.12 unsigned).

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `x0` in W: first sample of the pair, signed.
- `x1` in W: second sample of the pair, signed.
- `ivalid` in 1: pair valid. There is no backpressure to `myAWGN`.
- `gain` in 16: unsigned sigma multiplier, Q4.12; 0x1000 = 1.0. Sampled when the output register loads.
- `noise` out W: scaled sample, signed.
- `noise_valid` out 1: `noise` holds a sample.
- `noise_ready` in 1: consumer accepts the sample this cycle.
- `drop_cnt` out 16: count of dropped pairs; saturates at 0xFFFF.
- `overflow` out 1: sticky; set on the first drop.

## Operation
- Write side: when `ivalid` is high and the FIFO is not full (count < DEPTH), {x0, x1} is pushed. When `ivalid` is high and the FIFO is full, the pair is dropped, `drop_cnt` increments (saturating), and `overflow` is set to 1.
  - Full is evaluated on the pre-edge count. A pop in the same cycle does not make room for that cycle's write.
- Read side: a phase bit selects which sample to read, 0 = x0 and 1 = x1.
- The output register loads when the FIFO is non-empty and (`noise_valid` == 0 or `noise_ready` == 1).
  - Each load writes `noise` = sat(round(sample × gain)) and toggles phase.
  - A load with phase = 1 also pops the head pair.
- When no load happens but `noise_ready` is high, `noise_valid` clears.
- Arithmetic:
  - Product: signed W × unsigned 16 gives a signed (W+17)-bit product.
  - Rounding: add 2^(GAIN_FRAC−1), then arithmetic shift right by GAIN_FRAC (round half up: −1.5 → −1, 1.5 → 2).
  - Saturation: clamp to [−2^(W−1), 2^(W−1)−1].
- Simultaneous push and pop with the FIFO not full: both occur and the count is unchanged.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.

## Timing
- Reset values: `noise`=0, `noise_valid`=0, `drop_cnt`=0, `overflow`=0. FIFO is empty, pointers are 0, phase is 0.
- Reset mid-operation: all buffered pairs and any held output are discarded at the next edge with `resetn`=0.
- Latency: a pair sampled at edge k into an empty FIFO produces `noise_valid`=1 with its x0 after edge k+1. Its x1 follows after edge k+2 if `noise_ready`=1.
- Throughput: one sample per cycle, so the sustained input rate is at most one pair per two cycles without drops.
- Handshake: a sample transfers when `noise_valid` and `noise_ready` are both high. `noise` is stable while `noise_valid`=1 and `noise_ready`=0.
- `gain` changes take effect from the next load and never alter a held sample.

## Structure
- Package `awgn_pkg` holds `W`, `GAIN_FRAC`, the `SAT_MAX`/`SAT_MIN` constants, and a pair struct/typedef {x0, x1}.
- Sub-module `awgn_pair_fifo` is a synchronous FIFO of 2W-bit entries with push/pop/full/empty/count. The top level contains the phase FSM, scaler, saturation, output register, and drop counter.

## Test plan
- `gain`=0x1000, pair (0x0100, 0xFF00), `noise_ready`=1 -> `noise`=0x0100 after edge k+1, then 0xFF00 after edge k+2; `noise_valid` drops after edge k+3.
- Saturation, `gain`=0x4000: pair (0x4000, 0x8000) -> outputs 0x7FFF, 0x8000.
- Rounding, `gain`=0x0800: pair (0x0003, 0xFFFD) -> outputs 0x0002, 0xFFFF.
- Overflow, `noise_ready`=0, DEPTH=8: 10 consecutive pairs -> `drop_cnt`=2 and `overflow`=1. Then `noise_ready`=1 -> exactly 16 samples drain in arrival order.
- Stall: `noise_ready` held low for 5 cycles while `noise_valid`=1 -> `noise` is unchanged. When released, the next sample loads on the same edge as the transfer.
- Reset mid-stream: assert `resetn`=0 with 3 pairs buffered -> all outputs return to their reset values. The next pair after release appears with 1-cycle latency.
